// File: rtl/criq_pkg.sv
// Shared types and defaults for the multi-port circular queue.
// Pointers carry one extra wrap bit above the storage index.
package criq_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 16;
    localparam int DEF_PTRW  = clog2(DEF_DEPTH);
    localparam int DEF_ENQN  = 2;
    localparam int DEF_DEQN  = 2;

    typedef logic [DEF_PTRW:0] ptr_t;

endpackage

// File: rtl/criq_prefix_cnt.sv
// Counts the run of ones starting at bit 0 of an N-bit vector.
// Bits after the first zero do not contribute.
module criq_prefix_cnt #(
    parameter int N = 2,
    localparam int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec,
    output logic [CW-1:0] cnt
);

    logic run;

    always_comb begin
        cnt = '0;
        run = 1'b1;
        for (int i = 0; i < N; i++) begin
            run = run & vec[i];
            if (run) begin
                cnt = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/criq_mp.sv
// Multi-port in-order circular queue: ENQN writes and DEQN retires
// per cycle, with occupancy status, head window and synchronous flush.
module criq_mp
    import criq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTRW  = DEF_PTRW,
    parameter int ENQN  = DEF_ENQN,
    parameter int DEQN  = DEF_DEQN
) (
    input  logic                  Clk,
    input  logic                  Rest,
    input  logic [ENQN-1:0]       EnqValid,
    input  logic [ENQN*WIDTH-1:0] EnqData,
    output logic                  EnqReady,
    output logic [DEQN-1:0]       DeqValid,
    output logic [DEQN*WIDTH-1:0] DeqData,
    input  logic [DEQN-1:0]       DeqTake,
    input  logic                  Flush,
    output logic [PTRW:0]         Count,
    output logic [PTRW:0]         FreeCnt,
    output logic                  Full,
    output logic                  Empty,
    output logic [WIDTH-1:0]      Newest
);

    localparam int EW = clog2(ENQN + 1);
    localparam int DW = clog2(DEQN + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW:0]    head;
    logic [PTRW:0]    tail;
    logic [EW-1:0]    n_enq;
    logic [DW-1:0]    n_deq;
    logic [DEQN-1:0]  take_ok;
    logic             wr_ok;
    logic [PTRW-1:0]  newest_idx;

    criq_prefix_cnt #(.N(ENQN)) u_enq_cnt (
        .vec (EnqValid),
        .cnt (n_enq)
    );

    criq_prefix_cnt #(.N(DEQN)) u_deq_cnt (
        .vec (take_ok),
        .cnt (n_deq)
    );

    assign Count   = tail - head;
    assign FreeCnt = (PTRW+1)'(DEPTH) - Count;
    // Wrap bits differ with equal index only when every slot is used.
    assign Full    = (head[PTRW] != tail[PTRW]) &&
                     (head[PTRW-1:0] == tail[PTRW-1:0]);
    assign Empty   = (head == tail);
    assign EnqReady = (FreeCnt >= (PTRW+1)'(ENQN));
    assign take_ok = DeqTake & DeqValid;
    assign wr_ok   = EnqReady & ~Flush;

    for (genvar g = 0; g < DEQN; g++) begin : g_deq
        logic [PTRW-1:0] rd_idx;
        assign rd_idx = head[PTRW-1:0] + PTRW'(g);
        assign DeqValid[g] = (Count > (PTRW+1)'(g));
        assign DeqData[g*WIDTH +: WIDTH] = mem[rd_idx];
    end

    assign newest_idx = tail[PTRW-1:0] - PTRW'(1);
    assign Newest = Empty ? '0 : mem[newest_idx];

    always_ff @(posedge Clk) begin
        if (wr_ok) begin
            for (int i = 0; i < ENQN; i++) begin
                if (EW'(i) < n_enq) begin
                    mem[tail[PTRW-1:0] + PTRW'(i)] <=
                        EnqData[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            head <= '0;
            tail <= '0;
        end else if (Flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (EnqReady) begin
                tail <= tail + (PTRW+1)'(n_enq);
            end
            head <= head + (PTRW+1)'(n_deq);
        end
    end

endmodule

// File: tb/tb_criq_mp.sv
// Bench for criq_mp: directed steps plus random traffic against a
// queue-based reference model.
module tb_criq_mp;

    logic        Clk = 1'b0;
    logic        Rest;
    logic [1:0]  EnqValid;
    logic [63:0] EnqData;
    logic        EnqReady;
    logic [1:0]  DeqValid;
    logic [63:0] DeqData;
    logic [1:0]  DeqTake;
    logic        Flush;
    logic [4:0]  Count;
    logic [4:0]  FreeCnt;
    logic        Full;
    logic        Empty;
    logic [31:0] Newest;

    int total = 0;
    int bad = 0;
    logic [31:0] mq[$];
    logic [31:0] seq = 32'h1000;

    always #5 Clk = ~Clk;

    criq_mp dut (
        .Clk      (Clk),
        .Rest     (Rest),
        .EnqValid (EnqValid),
        .EnqData  (EnqData),
        .EnqReady (EnqReady),
        .DeqValid (DeqValid),
        .DeqData  (DeqData),
        .DeqTake  (DeqTake),
        .Flush    (Flush),
        .Count    (Count),
        .FreeCnt  (FreeCnt),
        .Full     (Full),
        .Empty    (Empty),
        .Newest   (Newest)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        int n;
        n = mq.size();
        chk({tag, ":count"}, 32'(Count), 32'(n));
        chk({tag, ":free"}, 32'(FreeCnt), 32'(16 - n));
        chk({tag, ":empty"}, 32'(Empty), 32'(n == 0));
        chk({tag, ":full"}, 32'(Full), 32'(n == 16));
        chk({tag, ":ready"}, 32'(EnqReady), 32'((16 - n) >= 2));
        chk({tag, ":dvalid"}, 32'(DeqValid), {30'd0, n > 1, n > 0});
        chk({tag, ":newest"}, Newest, (n > 0) ? mq[n-1] : 32'd0);
        for (int i = 0; i < 2; i++) begin
            if (n > i) begin
                chk($sformatf("%s:ddata%0d", tag, i),
                    DeqData[i*32 +: 32], mq[i]);
            end
        end
    endtask

    // Apply inputs, advance one edge, update the model, compare.
    task automatic step(string tag, logic [1:0] ev, logic [63:0] ed,
                        logic [1:0] tk, logic fl);
        int n;
        int ne;
        int nd;
        bit rdy;
        logic [1:0] vt;
        EnqValid = ev;
        EnqData  = ed;
        DeqTake  = tk;
        Flush    = fl;
        n   = mq.size();
        rdy = (16 - n) >= 2;
        ne  = ev[0] ? (ev[1] ? 2 : 1) : 0;
        vt  = tk & {n > 1, n > 0};
        nd  = vt[0] ? (vt[1] ? 2 : 1) : 0;
        @(posedge Clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            repeat (nd) void'(mq.pop_front());
            if (rdy) begin
                for (int i = 0; i < ne; i++) mq.push_back(ed[i*32 +: 32]);
            end
        end
        check_all(tag);
    endtask

    function automatic logic [63:0] nxt2();
        logic [63:0] d;
        d = {seq + 32'd1, seq};
        seq = seq + 32'd2;
        return d;
    endfunction

    initial begin
        Rest = 1'b1;
        EnqValid = '0;
        EnqData = '0;
        DeqTake = '0;
        Flush = 1'b0;
        #12;
        check_all("reset");
        @(negedge Clk);
        Rest = 1'b0;

        step("dual", 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 2'b00, 1'b0);
        step("noncontig", 2'b10, {32'hDEAD_0000, 32'hBEEF_0000}, 2'b00, 1'b0);

        for (int k = 0; k < 6; k++) step("fill", 2'b11, nxt2(), 2'b00, 1'b0);
        step("fill15", 2'b01, nxt2(), 2'b00, 1'b0);
        chk("at15:ready_lo", 32'(EnqReady), 32'd0);
        step("ref2", 2'b11, nxt2(), 2'b00, 1'b0);
        step("ref1", 2'b01, nxt2(), 2'b00, 1'b0);
        step("deq_full", 2'b11, nxt2(), 2'b11, 1'b0);

        while (mq.size() > 5) step("drain", 2'b00, '0, 2'b11, 1'b0);
        while (mq.size() > 4) step("drain1", 2'b00, '0, 2'b01, 1'b0);
        for (int k = 0; k < 20; k++) step("wrap", 2'b11, nxt2(), 2'b11, 1'b0);
        chk("wrap:const", 32'(Count), 32'd4);

        step("to5", 2'b01, nxt2(), 2'b00, 1'b0);
        step("flush", 2'b11, nxt2(), 2'b11, 1'b1);
        step("post_flush", 2'b01, {32'd0, 32'hF1F1_0000}, 2'b00, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            step("rand", 2'($urandom), d, 2'($urandom),
                 ($urandom_range(0, 15) == 0));
        end

        while (mq.size() < 6) step("pre_rst", 2'b11, nxt2(), 2'b00, 1'b0);
        EnqValid = 2'b00;
        DeqTake = 2'b00;
        Rest = 1'b1;
        #2;
        mq.delete();
        check_all("async_rst");
        EnqValid = 2'b11;
        EnqData = nxt2();
        @(posedge Clk);
        #1;
        check_all("rst_hold");
        @(negedge Clk);
        Rest = 1'b0;
        step("after_rst", 2'b01, {32'd0, 32'h5A5A_0001}, 2'b00, 1'b0);
        step("after_rst2", 2'b00, '0, 2'b01, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/criq_mp.md
Name: criq_mp

Overview:
- Parametrised multi-port circular queue; successor to the single-port CRIQ.
- Accepts up to ENQN entries and retires up to DEQN entries per cycle, in order.
- Exposes occupancy and free-slot counts, a head window of DEQN entries, the newest written entry, and a synchronous flush.
- Sits between the decode/rename front end and the issue/commit stages, where multi-wide buffering is needed.

Parameters:
- WIDTH, 32, bits per entry.
- DEPTH, 16, number of entries; power of two; DEPTH >= max(ENQN, DEQN).
- PTRW, 4, log2(DEPTH).
- ENQN, 2, enqueue lanes.
- DEQN, 2, dequeue lanes.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rest  in  1  reset; asynchronous, active-high.
- EnqValid  in  ENQN  per-lane write request; lane 0 is oldest.
- EnqData  in  ENQN*WIDTH  lane i occupies bits [i*WIDTH +: WIDTH].
- EnqReady  out  1  high when FreeCnt >= ENQN.
- DeqValid  out  DEQN  bit i high when Count > i.
- DeqData  out  DEQN*WIDTH  head window; lane i is entry head+i (mod DEPTH); combinational from storage.
- DeqTake  in  DEQN  per-lane retire request.
- Flush  in  1  synchronous clear of pointers.
- Count  out  PTRW+1  current occupancy, 0..DEPTH.
- FreeCnt  out  PTRW+1  DEPTH-Count.
- Full  out  1  Count==DEPTH.
- Empty  out  1  Count==0.
- Newest  out  WIDTH  most recently written valid entry; 0 when Empty.

Behaviour:
- State:
  - head and tail pointers, each PTRW+1 bits, with the MSB as wrap bit.
  - Count = tail-head, computed modulo 2^(PTRW+1).
  - Storage array of DEPTH x WIDTH.
- Reset (async, Rest=1): head=tail=0, so Count=0, FreeCnt=DEPTH, Empty=1, Full=0, DeqValid=0, Newest=0, EnqReady=1. Storage contents are don't-care (not reset).
- Enqueue:
  - nEnq = number of leading contiguous ones in EnqValid, starting at lane 0. Bits after the first zero are ignored.
  - Accepted only if EnqReady is high; all-or-nothing. If EnqReady is low, nothing is written and tail is unchanged.
  - Lane i writes storage[tail+i] and tail advances by nEnq. Wrap happens through pointer truncation.
  - EnqReady uses the current-cycle FreeCnt only; a same-cycle dequeue does not raise it.
- Dequeue:
  - nDeq = number of leading contiguous ones in (DeqTake & DeqValid). Head advances by nDeq.
  - A take on an invalid lane, or a non-contiguous bit, is ignored. The verification environment flags it as a protocol error.
- No bypass: an entry written at edge N appears on DeqData/DeqValid after edge N, not in the same cycle.
- Simultaneous enqueue and dequeue: both apply. Count_next = Count + nEnq - nDeq.
  - Full with EnqReady=0: a dequeue frees slots, but the enqueue is still refused this cycle.
- Flush: at the edge, head=tail=0 and all same-cycle enqueue/dequeue are discarded. Flush has priority over everything except reset.
- Newest: storage[tail-1] when Count != 0; otherwise 0. It reflects state after the last edge.
- Wrap-around: pointers increment modulo 2^(PTRW+1). Full/Empty are decided by wrap-bit comparison, never by index equality alone.
- Latency: enqueue-to-visible-at-head is 1 cycle when the queue is empty. All status outputs are combinational from registered state and glitch-safe relative to Clk.
- Reset asserted mid-operation: the queue empties immediately (async) and stays empty until Rest deasserts. The first enqueue after deassert lands at index 0.

Decomposition:
- Shared package `criq_pkg`:
  - localparam function clog2.
  - Default WIDTH/DEPTH constants.
  - A typedef for the pointer with wrap bit (PTRW+1).
- Sub-module `criq_prefix_cnt` (parameter N): counts leading contiguous ones in an N-bit vector and outputs $clog2(N+1) bits. Instantiated twice, once for nEnq and once for nDeq.

Test Plan:
- Reset then idle: Rest pulse → Count=0, FreeCnt=16, Empty=1, DeqValid=00, EnqReady=1, Newest=0.
- Dual enqueue: EnqValid=11 with A,B → next cycle Count=2, DeqData lane0=A, lane1=B, Newest=B.
- Non-contiguous enqueue: EnqValid=10 → nothing written, Count unchanged.
- Fill to 15 entries, then EnqValid=11 → EnqReady=0 and write refused. Then EnqValid=01 only → refused, because ready requires 2 free slots.
- Wrap-around: push and pop 2 per cycle for 20 cycles with incrementing data → DeqData stays in order across index 15→0, and Count stays constant.
- Simultaneous dequeue of 2, enqueue of 2 and Flush at Count=5 → next cycle Count=0, Empty=1. A subsequent single enqueue lands at index 0 and is visible the following cycle.
